// File: rtl/ks_addsub_pipe.sv
// ks_addsub_pipe: pipelined Kogge-Stone adder/subtractor with a valid/ready
// stream interface. The prefix tree is split across two register stages and
// a third stage registers the sum and the carry/overflow/zero flags.
// All three stages advance together whenever the output slot is free or is
// being consumed, so there is no bubble collapsing. The pipeline holds at
// most three beats.

module ks_addsub_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LVLS   = $clog2(WIDTH);
  localparam int LVL_S1 = LVLS / 2;

  logic             advance_s;

  // Front end: operand conditioning and the first half of the prefix tree.
  logic [WIDTH-1:0] bx_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] pre_g_s;
  logic [WIDTH-1:0] pre_p_s;
  logic [WIDTH-1:0] lo_g_nxt_s;
  logic [WIDTH-1:0] lo_p_nxt_s;

  // Stage 1 registers.
  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_p_r;
  logic [WIDTH-1:0] s1_g_r;
  logic [WIDTH-1:0] s1_pp_r;
  logic             s1_amsb_r;
  logic             s1_bmsb_r;
  logic             s1_cin_r;

  // Back half of the prefix tree; the group generate of bit i is carry c[i].
  logic [WIDTH-1:0] carry_s;
  logic [WIDTH-1:0] hi_p_s;
  logic [WIDTH-1:0] hi_g_nxt_s;
  logic [WIDTH-1:0] hi_p_nxt_s;

  // Stage 2 registers.
  logic             s2_valid_r;
  logic [WIDTH-1:0] s2_c_r;
  logic [WIDTH-1:0] s2_p_r;
  logic             s2_amsb_r;
  logic             s2_bmsb_r;
  logic             s2_cin_r;

  // Result formation ahead of the output register.
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;

  // The whole pipeline moves when the output slot is empty or being taken.
  assign advance_s = ~out_valid | out_ready;
  assign in_ready  = advance_s;

  // Condition b, form p/g with carry-in folded into bit 0, run the low prefix levels.
  always_comb begin
    bx_s       = b ^ {WIDTH{sub}};
    p_s        = a ^ bx_s;
    g_s        = a & bx_s;
    g_s[0]     = g_s[0] | (p_s[0] & sub);
    pre_g_s    = g_s;
    pre_p_s    = p_s;
    lo_g_nxt_s = g_s;
    lo_p_nxt_s = p_s;
    for (int k = 1; k <= LVL_S1; k++) begin
      lo_g_nxt_s = pre_g_s;
      lo_p_nxt_s = pre_p_s;
      for (int i = (1 << (k - 1)); i < WIDTH; i++) begin
        lo_g_nxt_s[i] = pre_g_s[i] | (pre_p_s[i] & pre_g_s[i - (1 << (k - 1))]);
        lo_p_nxt_s[i] = pre_p_s[i] & pre_p_s[i - (1 << (k - 1))];
      end
      pre_g_s = lo_g_nxt_s;
      pre_p_s = lo_p_nxt_s;
    end
  end

  // Stage 1: capture the partial prefix results and the MSB/carry-in side data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_p_r     <= {WIDTH{1'b0}};
      s1_g_r     <= {WIDTH{1'b0}};
      s1_pp_r    <= {WIDTH{1'b0}};
      s1_amsb_r  <= 1'b0;
      s1_bmsb_r  <= 1'b0;
      s1_cin_r   <= 1'b0;
    end else if (advance_s) begin
      s1_valid_r <= in_valid & advance_s;
      s1_p_r     <= p_s;
      s1_g_r     <= pre_g_s;
      s1_pp_r    <= pre_p_s;
      s1_amsb_r  <= a[WIDTH-1];
      s1_bmsb_r  <= bx_s[WIDTH-1];
      s1_cin_r   <= sub;
    end
  end

  // Remaining prefix levels turn the stage-1 group terms into final carries.
  always_comb begin
    carry_s    = s1_g_r;
    hi_p_s     = s1_pp_r;
    hi_g_nxt_s = s1_g_r;
    hi_p_nxt_s = s1_pp_r;
    for (int k = LVL_S1 + 1; k <= LVLS; k++) begin
      hi_g_nxt_s = carry_s;
      hi_p_nxt_s = hi_p_s;
      for (int i = (1 << (k - 1)); i < WIDTH; i++) begin
        hi_g_nxt_s[i] = carry_s[i] | (hi_p_s[i] & carry_s[i - (1 << (k - 1))]);
        hi_p_nxt_s[i] = hi_p_s[i] & hi_p_s[i - (1 << (k - 1))];
      end
      carry_s = hi_g_nxt_s;
      hi_p_s  = hi_p_nxt_s;
    end
  end

  // Stage 2: capture carries together with the bitwise propagate terms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_c_r     <= {WIDTH{1'b0}};
      s2_p_r     <= {WIDTH{1'b0}};
      s2_amsb_r  <= 1'b0;
      s2_bmsb_r  <= 1'b0;
      s2_cin_r   <= 1'b0;
    end else if (advance_s) begin
      s2_valid_r <= s1_valid_r;
      s2_c_r     <= carry_s;
      s2_p_r     <= s1_p_r;
      s2_amsb_r  <= s1_amsb_r;
      s2_bmsb_r  <= s1_bmsb_r;
      s2_cin_r   <= s1_cin_r;
    end
  end

  // Sum bits use the carry into each position; overflow compares operand and result signs.
  always_comb begin
    sum_s = s2_p_r ^ {s2_c_r[WIDTH-2:0], s2_cin_r};
    ovf_s = (s2_amsb_r == s2_bmsb_r) & (sum_s[WIDTH-1] != s2_amsb_r);
  end

  // Stage 3: registered outputs, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= {WIDTH{1'b0}};
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (advance_s) begin
      out_valid <= s2_valid_r;
      s         <= sum_s;
      cout      <= s2_c_r[WIDTH-1];
      ovf       <= ovf_s;
      zero      <= ~|sum_s;
    end
  end

endmodule

// File: tb/tb_ks_addsub_pipe.sv
// Scoreboard bench for ks_addsub_pipe: the driver pushes the expected result
// of every accepted beat, the monitor pops and compares each output beat.

module tb_ks_addsub_pipe;

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] s;
  logic        cout;
  logic        ovf;
  logic        zero;

  res_t exp_q[$];
  int   nchecks = 0;
  int   nerr    = 0;
  int   out_cnt = 0;

  ks_addsub_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: exact integer arithmetic on unsigned and signed views.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic op);
    res_t        r;
    logic [32:0] wide;
    longint      sx;
    longint      sy;
    longint      sr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (op) begin
      wide   = {1'b0, x} - {1'b0, y};
      r.cout = (x >= y);
      sr     = sx - sy;
    end else begin
      wide   = {1'b0, x} + {1'b0, y};
      r.cout = wide[32];
      sr     = sx + sy;
    end
    r.s    = wide[31:0];
    r.ovf  = (sr > SMAX) || (sr < SMIN);
    r.zero = (r.s == 32'd0);
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    nchecks++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // One cycle of stimulus: drive after the falling edge, record acceptance before the rising edge.
  task automatic step(input logic v, input logic [31:0] ai, input logic [31:0] bi,
                      input logic si, input logic ordy, input res_t e, output logic acc);
    @(negedge clk);
    in_valid  = v;
    a         = ai;
    b         = bi;
    sub       = si;
    out_ready = ordy;
    #2;
    acc = v & in_ready;
    if (acc) exp_q.push_back(e);
  endtask

  task automatic drain(input string nm);
    logic acc;
    int   n;
    n = 0;
    while (exp_q.size() > 0 && n < 30) begin
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, res_t'(0), acc);
      n++;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  // Single beat into an empty pipe; count rising edges, accepting edge included.
  task automatic lat_beat(input logic [31:0] ai, input logic [31:0] bi, input logic si,
                          input res_t e, input string nm);
    logic acc;
    int   lat;
    step(1'b1, ai, bi, si, 1'b1, e, acc);
    chk({nm, "_accept"}, 64'(acc), 64'd1);
    lat = 0;
    while (lat < 10) begin
      @(posedge clk);
      lat++;
      #1;
      in_valid = 1'b0;
      if (out_valid) break;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd3);
  endtask

  // Monitor: every presented output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    #3;
    if (!rst && out_valid) begin
      nchecks++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_output: got s=%h cout=%b ovf=%b zero=%b with empty scoreboard",
                 s, cout, ovf, zero);
      end else begin
        if ({s, cout, ovf, zero} !== exp_q[0]) begin
          nerr++;
          $display("FAIL result: got s=%h cout=%b ovf=%b zero=%b expected s=%h cout=%b ovf=%b zero=%b",
                   s, cout, ovf, zero, exp_q[0].s, exp_q[0].cout, exp_q[0].ovf, exp_q[0].zero);
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          out_cnt++;
        end
      end
    end
  end

  logic [31:0] dir_a [6] = '{32'h0000_0005, 32'h0000_0000, 32'h8000_0000,
                             32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA};
  logic [31:0] dir_b [6] = '{32'h0000_0005, 32'h0000_0001, 32'h0000_0001,
                             32'h0000_0001, 32'h0000_0001, 32'h5555_5555};
  logic        dir_sub [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  res_t        dir_exp [6] = '{{32'h0000_0000, 1'b1, 1'b0, 1'b1},
                               {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0},
                               {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0},
                               {32'h8000_0000, 1'b0, 1'b1, 1'b0},
                               {32'h0000_0000, 1'b1, 1'b0, 1'b1},
                               {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}};

  initial begin
    logic        acc;
    int          idx;
    int          nacc;
    int          guard;
    int          base_cnt;
    logic [31:0] bp_a [5];
    logic [31:0] bp_b [5];
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    // Power-on reset: outputs clear asynchronously.
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_flags", 64'({s, cout, ovf, zero}), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Directed edge cases; first one also measures latency.
    lat_beat(dir_a[0], dir_b[0], dir_sub[0], dir_exp[0], "sub_equal");
    for (int i = 1; i < 6; i++) begin
      step(1'b1, dir_a[i], dir_b[i], dir_sub[i], 1'b1, dir_exp[i], acc);
      chk("directed_accept", 64'(acc), 64'd1);
    end
    drain("directed_drain");

    // Backpressure: 5 beats offered with the consumer stalled.
    for (int i = 0; i < 5; i++) begin
      bp_a[i] = $urandom();
      bp_b[i] = $urandom();
    end
    base_cnt = out_cnt;
    idx  = 0;
    nacc = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, bp_a[idx], bp_b[idx], idx[0], 1'b0, model(bp_a[idx], bp_b[idx], idx[0]), acc);
      if (acc) begin
        idx++;
        nacc++;
      end
    end
    chk("bp_accepted", 64'(nacc), 64'd3);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    guard = 0;
    while (idx < 5 && guard < 20) begin
      step(1'b1, bp_a[idx], bp_b[idx], idx[0], 1'b1, model(bp_a[idx], bp_b[idx], idx[0]), acc);
      if (acc) idx++;
      guard++;
    end
    chk("bp_all_accepted", 64'(idx), 64'd5);
    drain("bp_drain");
    chk("bp_out_count", 64'(out_cnt - base_cnt), 64'd5);

    // Reset with two beats in flight.
    for (int i = 0; i < 2; i++) begin
      ra = $urandom();
      rb = $urandom();
      step(1'b1, ra, rb, 1'b0, 1'b1, model(ra, rb, 1'b0), acc);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst      = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_flags", 64'({s, cout, ovf, zero}), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, res_t'(0), acc);
    chk("midrst_no_output", 64'(out_valid), 64'd0);
    lat_beat(32'h0000_0010, 32'h0000_0003, 1'b1, res_t'({32'h0000_000D, 1'b1, 1'b0, 1'b0}),
             "after_rst");
    drain("after_rst_drain");

    // Random regression with random source and sink stalls.
    for (int c = 0; c < 10000; c++) begin
      ra = pick();
      rb = pick();
      rs = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 3) != 0), ra, rb, rs, 1'($urandom_range(0, 3) != 0),
           model(ra, rb, rs), acc);
    end
    drain("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
